// File: rtl/rns_reverse_converter_pipe.sv
// Three-stage reverse converter for the RNS moduli set {2^N+1, 2^N, 2^N-1}.
// X = x2 + 2^N * Y, with Y rebuilt modulo 2^2N-1 using rotations and end-around-carry adds.
module rns_reverse_converter_pipe #(
    parameter int N     = 30,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       x1,
    input  logic [N-1:0]     x2,
    input  logic [N-1:0]     x3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3*N-1:0]   out,
    output logic             out_err,
    output logic [CNT_W-1:0] conv_cnt
);
    localparam int W = 2 * N;
    localparam logic [N:0] X1_MAX = {1'b1, {N{1'b0}}};

    function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input int k);
        return (a << k) | (a >> (W - k));
    endfunction

    function automatic logic [W-1:0] eac(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    logic             en;
    logic [W-1:0]     z1, z2, z3;
    logic [W-1:0]     t1_d, t2_d, y_sum, y_d;
    logic             err_d;
    logic [3*N-1:0]   out_d;
    logic [CNT_W-1:0] cnt_d;

    logic             v1_q, v2_q, v3_q;
    logic             e1_q, e2_q, e3_q;
    logic [W-1:0]     t1_q, t2_q, y_q;
    logic [N-1:0]     x2a_q, x2b_q;
    logic [3*N-1:0]   out_q;
    logic [CNT_W-1:0] cnt_q;

    assign en       = out_ready || !v3_q;
    assign in_ready = en;

    assign z1 = {{(W-N-1){1'b0}}, x1};
    assign z2 = {{N{1'b0}}, x2};
    assign z3 = {{N{1'b0}}, x3};

    // Y = -x1*(2^(2N-1)-2^(N-1)) - x2*2^N + x3*(2^(2N-1)+2^(N-1))  mod 2^2N-1
    assign t1_d  = eac(rotl(z1, N - 1), ~rotl(z1, W - 1));
    assign t2_d  = eac(eac(~rotl(z2, N), rotl(z3, W - 1)), rotl(z3, N - 1));
    assign err_d = x1 > X1_MAX;

    assign y_sum = eac(t1_q, t2_q);
    assign y_d   = (&y_sum) ? '0 : y_sum;

    assign out_d = e2_q ? '0 : {y_q, x2b_q};
    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            e1_q  <= 1'b0;
            e2_q  <= 1'b0;
            e3_q  <= 1'b0;
            out_q <= '0;
        end else if (en) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            e1_q  <= in_valid && err_d;
            e2_q  <= v1_q && e1_q;
            e3_q  <= v2_q && e2_q;
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            t1_q  <= t1_d;
            t2_q  <= t2_d;
            x2a_q <= x2;
            y_q   <= y_d;
            x2b_q <= x2a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (v3_q && out_ready) begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign out_err   = e3_q;
    assign out       = out_q;
    assign conv_cnt  = cnt_q;

endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Bench for rns_reverse_converter_pipe: directed table, stall, reset and random
// traffic checked against an independent CRT model.
module tb_rns_reverse_converter_pipe;
    localparam int N  = 30;
    localparam int NV = 10;
    localparam logic [127:0] P  = 128'd1 << N;
    localparam logic [127:0] M1 = P + 128'd1;
    localparam logic [127:0] M2 = P;
    localparam logic [127:0] M3 = P - 128'd1;
    localparam logic [127:0] MM = M1 * M2 * M3;

    typedef struct {
        logic [N:0]   a1;
        logic [N-1:0] a2;
        logic [N-1:0] a3;
        logic [127:0] eo;
        logic         ee;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N:0]     x1;
    logic [N-1:0]   x2;
    logic [N-1:0]   x3;
    logic           out_valid;
    logic           out_ready;
    logic [3*N-1:0] out;
    logic           out_err;
    logic [31:0]    conv_cnt;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    logic mon_on = 1'b0;
    logic [127:0] inv1, inv2, inv3;
    logic [127:0] expq[$];
    logic         errq[$];
    vec_t tv[NV];
    vec_t st[5];

    always #5 clk = ~clk;

    rns_reverse_converter_pipe #(.N(N), .CNT_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x1(x1),
        .x2(x2),
        .x3(x3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .out_err(out_err),
        .conv_cnt(conv_cnt)
    );

    function automatic logic [127:0] modinv(input logic [127:0] a, input logic [127:0] m);
        logic signed [127:0] t, nt, r, nr, q, tmp;
        t  = 0;
        nt = 1;
        r  = $signed(m);
        nr = $signed(a % m);
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt;
            t   = nt;
            nt  = tmp;
            tmp = r - q * nr;
            r   = nr;
            nr  = tmp;
        end
        if (t < 0) t = t + $signed(m);
        return $unsigned(t);
    endfunction

    function automatic logic [127:0] crt(input logic [127:0] a1, input logic [127:0] a2,
                                         input logic [127:0] a3);
        logic [127:0] s;
        s = ((a1 % M1) * inv1 % M1) * (M2 * M3);
        s = s + ((a2 % M2) * inv2 % M2) * (M1 * M3);
        s = s + ((a3 % M3) * inv3 % M3) * (M1 * M2);
        return s % MM;
    endfunction

    function automatic vec_t mk(input logic [127:0] a1, input logic [127:0] a2,
                                input logic [127:0] a3, input logic [127:0] eo,
                                input logic ee);
        vec_t v;
        v.a1 = a1[N:0];
        v.a2 = a2[N-1:0];
        v.a3 = a3[N-1:0];
        v.eo = eo;
        v.ee = ee;
        return v;
    endfunction

    function automatic vec_t mkm(input logic [127:0] a1, input logic [127:0] a2,
                                 input logic [127:0] a3);
        if (a1 > P) return mk(a1, a2, a3, 128'd0, 1'b1);
        return mk(a1, a2, a3, crt(a1, a2, a3), 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [N:0] a1,
                        input logic [N-1:0] a2, input logic [N-1:0] a3,
                        input logic ordy, output logic acc);
        vec_t m;
        @(posedge clk);
        #1;
        rst_n     = r;
        in_valid  = v;
        x1        = a1;
        x2        = a2;
        x3        = a3;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc && mon_on) begin
            m = mkm({97'd0, a1}, {98'd0, a2}, {98'd0, a3});
            expq.push_back(m.eo);
            errq.push_back(m.ee);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            xfers++;
            if (mon_on) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got %0h want none", out);
                end else begin
                    chk("sb_out", {38'd0, out}, expq.pop_front());
                    chk("sb_err", {127'd0, out_err}, {127'd0, errq.pop_front()});
                end
            end
        end
    end

    initial begin
        logic acc;
        int k;
        int seen;
        int jj;
        logic [N:0] ra1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        x1 = '0;
        x2 = '0;
        x3 = '0;
        out_ready = 1'b0;
        inv1 = modinv((M2 * M3) % M1, M1);
        inv2 = modinv((M1 * M3) % M2, M2);
        inv3 = modinv((M1 * M2) % M3, M3);

        tv[0] = mk(0, 0, 0, 0, 1'b0);
        tv[1] = mk(1, 1, 1, 1, 1'b0);
        tv[2] = mk(P, P - 1, P - 2, MM - 1, 1'b0);
        tv[3] = mk(5, 7, P - 1, crt(5, 7, P - 1), 1'b0);
        tv[4] = mk(P + 1, 3, 4, 0, 1'b1);
        tv[5] = mk(9, 9, 9, 9, 1'b0);
        tv[6] = mk(P, 0, 1, P, 1'b0);
        tv[7] = mk(P - 1, 0, 2, 2 * P, 1'b0);
        tv[8] = mk(2 * P - 1, P - 1, 0, 0, 1'b1);
        tv[9] = mk(0, 0, P - 1, 0, 1'b0);

        st[0] = mkm(11, 22, 33);
        st[1] = mkm(P, 12345, P - 1);
        st[2] = mkm(P + 1, 1, 1);
        st[3] = mkm(100, 200, 300);
        st[4] = mkm(7, 8, 9);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {127'd0, out_valid}, 0);
        chk("rst_out", {38'd0, out}, 0);
        chk("rst_out_err", {127'd0, out_err}, 0);
        chk("rst_conv_cnt", {96'd0, conv_cnt}, 0);

        step(1'b1, 1'b0, '0, '0, '0, 1'b0, acc);
        chk("post_rst_in_ready", {127'd0, in_ready}, 1);

        for (int j = 0; j < NV + 3; j++) begin
            jj = (j < NV) ? j : 0;
            step(1'b1, j < NV, tv[jj].a1, tv[jj].a2, tv[jj].a3, 1'b1, acc);
            if (j < NV) chk($sformatf("tbl_accept_%0d", j), {127'd0, acc}, 1);
            chk($sformatf("tbl_valid_%0d", j), {127'd0, out_valid}, {127'd0, j >= 3});
            if (j >= 3) begin
                chk($sformatf("tbl_out_%0d", j - 3), {38'd0, out}, tv[j-3].eo);
                chk($sformatf("tbl_err_%0d", j - 3), {127'd0, out_err}, {127'd0, tv[j-3].ee});
            end
            chk($sformatf("tbl_cnt_%0d", j), {96'd0, conv_cnt},
                (j > 3) ? 128'(j - 3) : 128'd0);
        end
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
        chk("tbl_final_cnt", {96'd0, conv_cnt}, NV);
        chk("tbl_idle_valid", {127'd0, out_valid}, 0);

        mon_on = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b1, st[k].a1, st[k].a2, st[k].a3, 1'b0, acc);
            if (c >= 3) chk($sformatf("stall_in_ready_%0d", c), {127'd0, in_ready}, 0);
            if (acc) k++;
        end
        chk("stall_accepted", 128'(k), 3);
        for (int g = 0; g < 20 && k < 5; g++) begin
            step(1'b1, 1'b1, st[k].a1, st[k].a2, st[k].a3, 1'b1, acc);
            if (acc) k++;
        end
        chk("stall_all_accepted", 128'(k), 5);
        repeat (6) step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
        chk("stall_drain", 128'(expq.size()), 0);
        chk("stall_cnt", {96'd0, conv_cnt}, NV + 5);

        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, st[c].a1, st[c].a2, st[c].a3, 1'b0, acc);
        step(1'b0, 1'b1, st[3].a1, st[3].a2, st[3].a3, 1'b0, acc);
        expq.delete();
        errq.delete();
        xfers = 0;
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
        chk("rst_mid_valid", {127'd0, out_valid}, 0);
        chk("rst_mid_cnt", {96'd0, conv_cnt}, 0);
        seen = 0;
        repeat (6) begin
            step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
            if (out_valid) seen++;
        end
        chk("rst_mid_no_output", 128'(seen), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)
                ra1 = {1'b1, N'($urandom_range(32'h3fff_ffff, 1))};
            else
                ra1 = (N+1)'($urandom_range(32'h4000_0000, 0));
            step(1'b1, $urandom_range(3) != 0, ra1, N'($urandom()),
                 N'($urandom_range(32'h3fff_ffff, 0)), $urandom_range(9) < 7, acc);
        end
        repeat (8) step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
        chk("rand_drain", 128'(expq.size()), 0);
        chk("rand_cnt", {96'd0, conv_cnt}, {96'd0, 32'(xfers)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
